pwm_motor_drive: RTL and testbench
==================================

PWM_MOTOR_DRIVE -- requirements
Module: pwm_motor_drive

Interface
REQ-001 Parameter DIV, default 390, PCLK cycles per PWM tick, legal range 1..65535 (about 1 kHz PWM at 100 MHz).
REQ-002 Parameter DEAD_PERIODS, default 4, whole PWM periods of forced-off time on a direction reversal, legal range 1..15.
REQ-003 PCLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 PRESERN  in  1  reset, synchronous, active-low.
REQ-005 PWM_DUTY_R, PWM_DUTY_L  in  8 each  requested duty per channel; the high count per 256-tick period.
REQ-006 PWM_EN_R, PWM_EN_L  in  1 each  channel enable request.
REQ-007 PWM_DIR_R, PWM_DIR_L  in  1 each  direction request; 0 = forward, 1 = reverse.
REQ-008 R_IN1, R_IN2, L_IN1, L_IN2  out  1 each  H-bridge inputs; IN1 is the forward leg, IN2 is the reverse leg; registered.
REQ-009 PERIOD_TICK  out  1  one-PCLK pulse at each PWM period boundary; registered.

Function
REQ-010 Prescaler counts 0..DIV-1 and wraps; a tick occurs in the cycle where the prescaler equals DIV-1.
REQ-011 The 8-bit counter CNT increments on each tick and wraps 255->0; no other event changes CNT.
REQ-012 A period boundary is a tick cycle with CNT=255; PERIOD_TICK is high in the following cycle only.
REQ-013 Each channel holds shadow registers DUTY_SH and DIR_SH; inputs are sampled only at a period boundary, never mid-period.
REQ-014 PWM level = (CNT < DUTY_SH), unsigned 8-bit compare; duty 0 is always low; duty 255 is high for 255 of 256 ticks.
REQ-015 Outputs are registered one PCLK after CNT/state update: RUN with DIR_SH=0 drives IN1=level and IN2=0; RUN with DIR_SH=1 drives IN1=0 and IN2=level; IDLE and DEAD drive both legs 0.
REQ-016 IN1 and IN2 of a channel are never both 1 in any cycle.
REQ-017 Each channel runs an independent FSM with states IDLE, RUN and DEAD; transitions are evaluated only at period boundaries.
REQ-018 IDLE->RUN when EN=1: load DUTY_SH and DIR_SH, with no dead time.
REQ-019 RUN, EN=0 -> IDLE; DUTY_SH is cleared to 0.
REQ-020 RUN, EN=1, DIR equal to DIR_SH -> stay in RUN and load DUTY_SH.
REQ-021 RUN, EN=1, DIR not equal to DIR_SH -> see REQ-026/REQ-027.
REQ-022 DEAD: a 4-bit DCNT decrements at each boundary; at the boundary where DCNT reaches 0, go to RUN if EN=1 (loading DUTY_SH and DIR_SH from the current inputs), else go to IDLE.
REQ-023 DEAD with EN=0 at any boundary -> IDLE immediately, without waiting for DCNT.
REQ-024 Input toggles between boundaries have no effect; only the value present in the boundary cycle is used.
REQ-025 Channels R and L share the prescaler and CNT, so boundaries are simultaneous on both channels.

Configuration
REQ-026 Macro PWM_DEADTIME_EN defined: a direction reversal per REQ-021 enters DEAD, both legs go 0 and DCNT=DEAD_PERIODS, giving exactly DEAD_PERIODS full periods off before the new direction drives.
REQ-027 PWM_DEADTIME_EN undefined: no DEAD state or DCNT is built; a reversal per REQ-021 loads DIR_SH and DUTY_SH at the boundary and the new leg drives from the next period.

Reset
REQ-028 PRESERN=0 at a clock edge clears the prescaler, CNT, all shadows, DCNT, both FSMs (to IDLE) and all outputs to 0 at that edge, including mid-period and mid-DEAD.
REQ-029 After release, the first PERIOD_TICK occurs 256*DIV+1 cycles after the first non-reset edge.

Verification (DIV=2, DEAD_PERIODS=2)
REQ-030 EN_R=1, DIR_R=0, DUTY_R=128 -> from the 2nd period on, R_IN1 is high 256 cycles of each 512-cycle period and R_IN2 stays 0.
REQ-031 DUTY_R changes 64->192 mid-period -> the current period still shows 128 high cycles and the next period shows 384.
REQ-032 PWM_DEADTIME_EN defined, running DUTY_R=100 forward, DIR_R flips to 1 -> both R legs are 0 for exactly 1024 cycles, then R_IN2 pulses 200 cycles per period.
REQ-033 PWM_DEADTIME_EN undefined, same stimulus as REQ-032 -> R_IN2 pulses in the period immediately after the boundary; R_IN1 and R_IN2 never overlap.
REQ-034 DUTY_L=0 gives L legs constantly 0; DUTY_L=255 gives 510 high cycles of 512; EN_L=0 mid-period keeps driving until the boundary, then both L legs are 0.
REQ-035 PRESERN=0 for 1 cycle mid-period while both channels run -> all outputs are 0 on the next edge and PERIOD_TICK is next seen 513 cycles after release.

Source files
------------

// File: rtl/pwm_motor_drive.sv
// Dual-channel H-bridge PWM driver: shared prescaler/256-step counter, per-channel IDLE/RUN(/DEAD) FSM.
// Optional macro PWM_DEADTIME_EN builds the DEAD state that forces whole off-periods on direction reversal.
module pwm_motor_drive #(
   parameter int DIV          = 390,
   parameter int DEAD_PERIODS = 4
) (
   input  logic       PCLK,
   input  logic       PRESERN,
   input  logic [7:0] PWM_DUTY_R,
   input  logic [7:0] PWM_DUTY_L,
   input  logic       PWM_EN_R,
   input  logic       PWM_EN_L,
   input  logic       PWM_DIR_R,
   input  logic       PWM_DIR_L,
   output logic       R_IN1,
   output logic       R_IN2,
   output logic       L_IN1,
   output logic       L_IN2,
   output logic       PERIOD_TICK
);

   localparam logic [15:0] PRESC_LAST = 16'(DIV - 1);
   localparam logic [1:0]  ST_IDLE    = 2'd0;
   localparam logic [1:0]  ST_RUN     = 2'd1;
`ifdef PWM_DEADTIME_EN
   localparam logic [1:0]  ST_DEAD    = 2'd2;
   localparam logic [3:0]  DEAD_LOAD  = 4'(DEAD_PERIODS);
`endif

   if (DIV < 1 || DIV > 65535) begin : g_bad_div
      $error("pwm_motor_drive: DIV out of range 1..65535");
   end
   if (DEAD_PERIODS < 1 || DEAD_PERIODS > 15) begin : g_bad_dead
      $error("pwm_motor_drive: DEAD_PERIODS out of range 1..15");
   end

   logic [15:0] presc_reg;
   logic [7:0]  cnt_reg;
   logic        period_tick_reg;
   logic        tick;
   logic        boundary;

   assign tick     = (presc_reg == PRESC_LAST);
   assign boundary = tick && (cnt_reg == 8'hFF);

   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         presc_reg       <= '0;
         cnt_reg         <= '0;
         period_tick_reg <= 1'b0;
      end else begin
         presc_reg       <= tick ? 16'd0 : presc_reg + 16'd1;
         if (tick) begin
            cnt_reg <= cnt_reg + 8'd1;
         end
         period_tick_reg <= boundary;
      end
   end

   assign PERIOD_TICK = period_tick_reg;

   // Channel index 0 is the right motor, 1 is the left motor.
   logic [7:0] duty_in [2];
   logic [1:0] en_in;
   logic [1:0] dir_in;
   logic [1:0] in1_out;
   logic [1:0] in2_out;

   assign duty_in[0] = PWM_DUTY_R;
   assign duty_in[1] = PWM_DUTY_L;
   assign en_in      = {PWM_EN_L, PWM_EN_R};
   assign dir_in     = {PWM_DIR_L, PWM_DIR_R};

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic [1:0] state_reg, state_next;
      logic [7:0] duty_reg, duty_next;
      logic       dir_reg, dir_next;
      logic       in1_reg, in2_reg;
      logic       level;
`ifdef PWM_DEADTIME_EN
      logic [3:0] dcnt_reg, dcnt_next;
`endif

      assign level = (cnt_reg < duty_reg);

      // Shadows and state move only in the boundary cycle; the new values take effect with CNT=0.
      always_comb begin
         state_next = state_reg;
         duty_next  = duty_reg;
         dir_next   = dir_reg;
`ifdef PWM_DEADTIME_EN
         dcnt_next  = dcnt_reg;
`endif
         if (boundary) begin
            case (state_reg)
               ST_IDLE: begin
                  if (en_in[gi]) begin
                     state_next = ST_RUN;
                     duty_next  = duty_in[gi];
                     dir_next   = dir_in[gi];
                  end
               end
               ST_RUN: begin
                  if (!en_in[gi]) begin
                     state_next = ST_IDLE;
                     duty_next  = 8'd0;
                  end else if (dir_in[gi] == dir_reg) begin
                     duty_next = duty_in[gi];
                  end else begin
`ifdef PWM_DEADTIME_EN
                     state_next = ST_DEAD;
                     dcnt_next  = DEAD_LOAD;
`else
                     duty_next  = duty_in[gi];
                     dir_next   = dir_in[gi];
`endif
                  end
               end
`ifdef PWM_DEADTIME_EN
               ST_DEAD: begin
                  if (!en_in[gi]) begin
                     state_next = ST_IDLE;
                     duty_next  = 8'd0;
                     dcnt_next  = 4'd0;
                  end else if (dcnt_reg <= 4'd1) begin
                     state_next = ST_RUN;
                     duty_next  = duty_in[gi];
                     dir_next   = dir_in[gi];
                     dcnt_next  = 4'd0;
                  end else begin
                     dcnt_next = dcnt_reg - 4'd1;
                  end
               end
`endif
               default: begin
                  state_next = ST_IDLE;
                  duty_next  = 8'd0;
               end
            endcase
         end
      end

      always_ff @(posedge PCLK) begin
         if (!PRESERN) begin
            state_reg <= ST_IDLE;
            duty_reg  <= '0;
            dir_reg   <= 1'b0;
            in1_reg   <= 1'b0;
            in2_reg   <= 1'b0;
`ifdef PWM_DEADTIME_EN
            dcnt_reg  <= '0;
`endif
         end else begin
            state_reg <= state_next;
            duty_reg  <= duty_next;
            dir_reg   <= dir_next;
`ifdef PWM_DEADTIME_EN
            dcnt_reg  <= dcnt_next;
`endif
            // Legs are mutually exclusive by construction: only one is gated by dir_reg.
            in1_reg   <= (state_reg == ST_RUN) && !dir_reg && level;
            in2_reg   <= (state_reg == ST_RUN) &&  dir_reg && level;
         end
      end

      assign in1_out[gi] = in1_reg;
      assign in2_out[gi] = in2_reg;
   end

   assign R_IN1 = in1_out[0];
   assign R_IN2 = in2_out[0];
   assign L_IN1 = in1_out[1];
   assign L_IN2 = in2_out[1];

endmodule

// File: tb/tb_pwm_motor_drive.sv
// Directed bench for pwm_motor_drive at DIV=2, DEAD_PERIODS=2 (512-cycle PWM periods).
// Each measured window starts at a PERIOD_TICK cycle; d duty steps show as 2*d high cycles per window.
module tb_pwm_motor_drive;

   logic       PCLK = 1'b0;
   logic       PRESERN = 1'b0;
   logic [7:0] PWM_DUTY_R = 8'd0;
   logic [7:0] PWM_DUTY_L = 8'd0;
   logic       PWM_EN_R = 1'b0;
   logic       PWM_EN_L = 1'b0;
   logic       PWM_DIR_R = 1'b0;
   logic       PWM_DIR_L = 1'b0;
   logic       R_IN1, R_IN2, L_IN1, L_IN2, PERIOD_TICK;

   int n_cmp = 0;
   int n_err = 0;
   int m_r1, m_r2, m_l1, m_l2, m_len, m_ovl;

   pwm_motor_drive #(.DIV(2), .DEAD_PERIODS(2)) dut (
      .PCLK        (PCLK),
      .PRESERN     (PRESERN),
      .PWM_DUTY_R  (PWM_DUTY_R),
      .PWM_DUTY_L  (PWM_DUTY_L),
      .PWM_EN_R    (PWM_EN_R),
      .PWM_EN_L    (PWM_EN_L),
      .PWM_DIR_R   (PWM_DIR_R),
      .PWM_DIR_L   (PWM_DIR_L),
      .R_IN1       (R_IN1),
      .R_IN2       (R_IN2),
      .L_IN1       (L_IN1),
      .L_IN2       (L_IN2),
      .PERIOD_TICK (PERIOD_TICK)
   );

   always #5 PCLK = ~PCLK;

   // Called at a window start (PERIOD_TICK high, #1 after the edge); returns at the next window start.
   // chg_sel 1 writes DUTY_R, 2 writes EN_L, after chg_at cycles of the window.
   task automatic measure_period(input int chg_at, input int chg_sel, input logic [7:0] chg_val);
      m_r1 = 0; m_r2 = 0; m_l1 = 0; m_l2 = 0; m_len = 0; m_ovl = 0;
      for (int i = 0; i < 2000; i++) begin
         if (i > 0) begin
            @(posedge PCLK); #1;
            if (PERIOD_TICK) break;
         end
         m_r1  += int'(R_IN1);
         m_r2  += int'(R_IN2);
         m_l1  += int'(L_IN1);
         m_l2  += int'(L_IN2);
         m_ovl += int'((R_IN1 & R_IN2) | (L_IN1 & L_IN2));
         m_len++;
         if (m_len == chg_at) begin
            case (chg_sel)
               1: PWM_DUTY_R = chg_val;
               2: PWM_EN_L   = chg_val[0];
               default: ;
            endcase
         end
      end
   endtask

   task automatic test_reset();
      int cyc;
      repeat (3) @(posedge PCLK);
      #1;
      n_cmp++;
      if ({R_IN1, R_IN2, L_IN1, L_IN2, PERIOD_TICK} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected 00000", {R_IN1, R_IN2, L_IN1, L_IN2, PERIOD_TICK});
      end
      PRESERN = 1'b1;
      cyc = 1;
      for (int i = 0; i < 2000; i++) begin
         @(posedge PCLK); #1;
         cyc++;
         if (PERIOD_TICK) break;
      end
      n_cmp++;
      if (cyc !== 513) begin
         n_err++;
         $display("FAIL first_period_tick: got cycle %0d expected 513", cyc);
      end
      $display("reset: first PERIOD_TICK in cycle %0d", cyc);
   endtask

   task automatic test_run_forward();
      int exp_r1 [3] = '{0, 256, 256};
      PWM_EN_R = 1'b1; PWM_DIR_R = 1'b0; PWM_DUTY_R = 8'd128;
      for (int p = 0; p < 3; p++) begin
         measure_period(-1, 0, 8'd0);
         n_cmp++;
         if (m_r1 !== exp_r1[p] || m_r2 !== 0 || m_l1 !== 0 || m_l2 !== 0 || m_len !== 512 || m_ovl !== 0) begin
            n_err++;
            $display("FAIL run_forward[%0d]: got r1=%0d r2=%0d l1=%0d l2=%0d len=%0d ovl=%0d expected r1=%0d r2=0 l1=0 l2=0 len=512 ovl=0",
                     p, m_r1, m_r2, m_l1, m_l2, m_len, m_ovl, exp_r1[p]);
         end
         $display("run_forward period %0d: r1=%0d r2=%0d len=%0d", p, m_r1, m_r2, m_len);
      end
   endtask

   task automatic test_duty_update();
      int exp_r1 [3] = '{256, 128, 384};
      PWM_DUTY_R = 8'd64;
      for (int p = 0; p < 3; p++) begin
         // Middle period: DUTY_R jumps to 192 mid-period and must not show until the next one.
         measure_period((p == 1) ? 100 : -1, 1, 8'd192);
         n_cmp++;
         if (m_r1 !== exp_r1[p] || m_r2 !== 0 || m_len !== 512) begin
            n_err++;
            $display("FAIL duty_update[%0d]: got r1=%0d r2=%0d len=%0d expected r1=%0d r2=0 len=512",
                     p, m_r1, m_r2, m_len, exp_r1[p]);
         end
         $display("duty_update period %0d: r1=%0d r2=%0d", p, m_r1, m_r2);
      end
   endtask

   task automatic test_reversal();
`ifdef PWM_DEADTIME_EN
      int exp_r2 [5] = '{0, 0, 0, 0, 200};
`else
      int exp_r2 [5] = '{0, 0, 200, 200, 200};
`endif
      int exp_r1 [5] = '{384, 200, 0, 0, 0};
      PWM_DUTY_R = 8'd100;
      for (int p = 0; p < 5; p++) begin
         if (p == 1) PWM_DIR_R = 1'b1;
         measure_period(-1, 0, 8'd0);
         n_cmp++;
         if (m_r1 !== exp_r1[p] || m_r2 !== exp_r2[p] || m_len !== 512 || m_ovl !== 0) begin
            n_err++;
            $display("FAIL reversal[%0d]: got r1=%0d r2=%0d len=%0d ovl=%0d expected r1=%0d r2=%0d len=512 ovl=0",
                     p, m_r1, m_r2, m_len, m_ovl, exp_r1[p], exp_r2[p]);
         end
         $display("reversal period %0d: r1=%0d r2=%0d", p, m_r1, m_r2);
      end
   endtask

   task automatic test_left_channel();
      int exp_l1 [5] = '{0, 0, 510, 510, 0};
      PWM_EN_L = 1'b1; PWM_DIR_L = 1'b0; PWM_DUTY_L = 8'd0;
      for (int p = 0; p < 5; p++) begin
         if (p == 1) PWM_DUTY_L = 8'd255;
         // Period 3: EN_L drops mid-period; driving continues to the boundary.
         measure_period((p == 3) ? 100 : -1, 2, 8'd0);
         n_cmp++;
         if (m_l1 !== exp_l1[p] || m_l2 !== 0 || m_r1 !== 0 || m_r2 !== 200 || m_len !== 512 || m_ovl !== 0) begin
            n_err++;
            $display("FAIL left_channel[%0d]: got l1=%0d l2=%0d r1=%0d r2=%0d len=%0d expected l1=%0d l2=0 r1=0 r2=200 len=512",
                     p, m_l1, m_l2, m_r1, m_r2, m_len, exp_l1[p]);
         end
         $display("left_channel period %0d: l1=%0d l2=%0d r2=%0d", p, m_l1, m_l2, m_r2);
      end
   endtask

   task automatic test_reset_mid_run();
      int exp_l1 [2] = '{0, 510};
      int cyc;
      PWM_EN_L = 1'b1;
      for (int p = 0; p < 2; p++) begin
         measure_period(-1, 0, 8'd0);
         n_cmp++;
         if (m_l1 !== exp_l1[p] || m_r2 !== 200) begin
            n_err++;
            $display("FAIL rerun_left[%0d]: got l1=%0d r2=%0d expected l1=%0d r2=200", p, m_l1, m_r2, exp_l1[p]);
         end
      end
      repeat (100) @(posedge PCLK);
      #1;
      n_cmp++;
      if ({R_IN1, R_IN2, L_IN1, L_IN2} !== 4'b0110) begin
         n_err++;
         $display("FAIL pre_reset_drive: got %b expected 0110", {R_IN1, R_IN2, L_IN1, L_IN2});
      end
      PRESERN = 1'b0;
      @(posedge PCLK); #1;
      n_cmp++;
      if ({R_IN1, R_IN2, L_IN1, L_IN2, PERIOD_TICK} !== 5'b0) begin
         n_err++;
         $display("FAIL mid_reset_outputs: got %b expected 00000", {R_IN1, R_IN2, L_IN1, L_IN2, PERIOD_TICK});
      end
      PRESERN = 1'b1;
      cyc = 1;
      for (int i = 0; i < 2000; i++) begin
         @(posedge PCLK); #1;
         cyc++;
         if (PERIOD_TICK) break;
      end
      n_cmp++;
      if (cyc !== 513) begin
         n_err++;
         $display("FAIL mid_reset_period_tick: got cycle %0d expected 513", cyc);
      end
      $display("reset_mid_run: PERIOD_TICK in cycle %0d after release", cyc);
   endtask

   initial begin
      test_reset();
      test_run_forward();
      test_duty_update();
      test_reversal();
      test_left_channel();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
